// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// pc_sequencer_pkg : shared definitions for the PC fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_ADD1   = 3'd2,
        ST_ADD2   = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    localparam logic [31:0] C_INSTR_BYTES  = 32'd4;
    localparam logic [31:0] C_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] C_WORD_MASK    = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & C_WORD_MASK;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : architectural PC, fetch handshake and next-PC operand drive
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = C_RESET_VECTOR,
    parameter logic [31:0] INSTR_BYTES  = C_INSTR_BYTES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    input  logic        branch_valid,
    input  logic [31:0] branch_offset,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    output logic        redirect_ack,
    input  logic        halt,
    output logic        halted,
    output logic [31:0] adder_op1,
    output logic [31:0] adder_op2,
    input  logic [31:0] adder_sum
);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic        req_q;
    logic        ack_q;
    logic        halted_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RST;
            pc_q     <= RESET_VECTOR;
            op1_q    <= 32'd0;
            op2_q    <= 32'd0;
            req_q    <= 1'b0;
            ack_q    <= 1'b0;
            halted_q <= 1'b0;
        end else if (en) begin
            ack_q <= 1'b0;
            case (state_q)
                ST_RST: begin
                    state_q <= ST_FETCH;
                    req_q   <= 1'b1;
                end
                ST_FETCH: begin
                    // halt outranks a handshake in the same cycle
                    if (halt) begin
                        state_q  <= ST_HALTED;
                        req_q    <= 1'b0;
                        halted_q <= 1'b1;
                    end else if (imem_ready) begin
                        state_q <= ST_ADD1;
                        req_q   <= 1'b0;
                        if (jump_valid) begin
                            op1_q <= word_align(jump_target);
                            op2_q <= 32'd0;
                            ack_q <= 1'b1;
                        end else if (branch_valid) begin
                            op1_q <= pc_q;
                            op2_q <= branch_offset;
                            ack_q <= 1'b1;
                        end else begin
                            op1_q <= pc_q;
                            op2_q <= INSTR_BYTES;
                        end
                    end
                end
                ST_ADD1: begin
                    state_q <= ST_ADD2;
                end
                ST_ADD2: begin
                    // the peer adder has registered op1+op2 by now
                    pc_q    <= word_align(adder_sum);
                    state_q <= ST_FETCH;
                    req_q   <= 1'b1;
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_RST;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign redirect_ack = ack_q;
    assign halted       = halted_q;
    assign adder_op1    = op1_q;
    assign adder_op2    = op2_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer : randomized bench for pc_sequencer with a registered peer adder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        imem_ready = 1'b0;
    logic        branch_valid = 1'b0;
    logic        jump_valid = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] branch_offset = 32'd0;
    logic [31:0] jump_target = 32'd0;

    logic        imem_req, redirect_ack, halted;
    logic [31:0] imem_addr, pc, adder_op1, adder_op2;
    logic [31:0] adder_sum;

    logic        w_req, w_ack, w_halted;
    logic [31:0] w_addr, w_pc, w_op1, w_op2;
    logic [31:0] w_sum;

    int          total = 0;
    int          passed = 0;
    logic [31:0] model_pc;

    always #5 clock = ~clock;

    // peer adders: result registered one clock after operands
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            adder_sum <= 32'd0;
            w_sum     <= 32'd0;
        end else begin
            adder_sum <= adder_op1 + adder_op2;
            w_sum     <= w_op1 + w_op2;
        end
    end

    pc_sequencer dut (
        .clock(clock), .reset(reset), .en(en),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_addr(imem_addr), .pc(pc),
        .branch_valid(branch_valid), .branch_offset(branch_offset),
        .jump_valid(jump_valid), .jump_target(jump_target),
        .redirect_ack(redirect_ack), .halt(halt), .halted(halted),
        .adder_op1(adder_op1), .adder_op2(adder_op2), .adder_sum(adder_sum)
    );

    pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_w (
        .clock(clock), .reset(reset), .en(en),
        .imem_req(w_req), .imem_ready(imem_ready), .imem_addr(w_addr), .pc(w_pc),
        .branch_valid(1'b0), .branch_offset(32'd0),
        .jump_valid(1'b0), .jump_target(32'd0),
        .redirect_ack(w_ack), .halt(1'b0), .halted(w_halted),
        .adder_op1(w_op1), .adder_op2(w_op2), .adder_sum(w_sum)
    );

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; imem_ready = 1'b0; jump_valid = 1'b0; branch_valid = 1'b0;
        halt = 1'b0; en = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        model_pc = 32'd0;
    endtask

    // One complete fetch transaction; the model decides the next PC from the redirect rules.
    task automatic fetch(input bit jv, input logic [31:0] jt, input bit bv,
                         input logic [31:0] bo, input int gap);
        int n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            @(negedge clock); n++;
        end
        total++;
        if (imem_req !== 1'b1) $display("FAIL fetch_req_timeout: imem_req=%b want 1", imem_req);
        else passed++;
        total++;
        if (imem_addr !== model_pc) $display("FAIL fetch_addr: got %h want %h", imem_addr, model_pc);
        else passed++;
        for (int g = 0; g < gap; g++) begin
            @(negedge clock);
            total++;
            if (imem_req !== 1'b1 || imem_addr !== model_pc)
                $display("FAIL stall_hold: req=%b addr=%h want 1/%h", imem_req, imem_addr, model_pc);
            else passed++;
        end
        jump_valid = jv; jump_target = jt; branch_valid = bv; branch_offset = bo;
        imem_ready = 1'b1;
        @(negedge clock);
        imem_ready = 1'b0;
        total++;
        if (redirect_ack !== (jv | bv) || imem_req !== 1'b0)
            $display("FAIL ack_add1: ack=%b req=%b want %b/0", redirect_ack, imem_req, jv | bv);
        else passed++;
        jump_valid = 1'b0; branch_valid = 1'b0;
        if (jv)      model_pc = jt & 32'hFFFF_FFFC;
        else if (bv) model_pc = (model_pc + bo) & 32'hFFFF_FFFC;
        else         model_pc = model_pc + 32'd4;
        @(negedge clock);
        total++;
        if (redirect_ack !== 1'b0 || imem_req !== 1'b0)
            $display("FAIL ack_add2: ack=%b req=%b want 0/0", redirect_ack, imem_req);
        else passed++;
        @(negedge clock);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== model_pc)
            $display("FAIL next_fetch: req=%b addr=%h want 1/%h", imem_req, imem_addr, model_pc);
        else passed++;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (imem_req !== 1'b0 || pc !== 32'd0 || halted !== 1'b0 || redirect_ack !== 1'b0 ||
            adder_op1 !== 32'd0 || adder_op2 !== 32'd0)
            $display("FAIL reset_values: req=%b pc=%h halted=%b ack=%b op1=%h op2=%h want all 0",
                     imem_req, pc, halted, redirect_ack, adder_op1, adder_op2);
        else passed++;
        @(negedge clock);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0)
            $display("FAIL first_req: req=%b addr=%h want 1/00000000", imem_req, imem_addr);
        else passed++;
    endtask

    task automatic test_sequential();
        fetch(1'b0, 32'd0, 1'b0, 32'd0, 0);
        fetch(1'b0, 32'd0, 1'b0, 32'd0, 0);
        total++;
        if (imem_addr !== 32'h8) $display("FAIL seq_addr8: got %h want 00000008", imem_addr);
        else passed++;
    endtask

    task automatic test_branch();
        fetch(1'b0, 32'd0, 1'b1, 32'h10, 0);
        total++;
        if (imem_addr !== 32'h18) $display("FAIL branch_target: got %h want 00000018", imem_addr);
        else passed++;
    endtask

    task automatic test_jump_branch();
        fetch(1'b1, 32'h400, 1'b1, 32'h40, 0);
        total++;
        if (imem_addr !== 32'h400) $display("FAIL jump_wins: got %h want 00000400", imem_addr);
        else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clock);
        total++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_start: req=%b addr=%h want 1/fffffffc", w_req, w_addr);
        else passed++;
        fetch(1'b0, 32'd0, 1'b0, 32'd0, 0);
        total++;
        if (w_addr !== 32'h0) $display("FAIL wrap_next: got %h want 00000000", w_addr);
        else passed++;
    endtask

    task automatic test_freeze();
        logic [31:0] old_pc;
        old_pc = model_pc;
        imem_ready = 1'b1;
        @(negedge clock);
        imem_ready = 1'b0;
        en = 1'b0;
        model_pc = model_pc + 32'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            total++;
            if (pc !== old_pc || adder_op1 !== old_pc || adder_op2 !== 32'd4 || imem_req !== 1'b0)
                $display("FAIL en_freeze: pc=%h op1=%h op2=%h req=%b want %h/%h/4/0",
                         pc, adder_op1, adder_op2, imem_req, old_pc, old_pc);
            else passed++;
        end
        en = 1'b1;
        @(negedge clock);
        @(negedge clock);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== model_pc)
            $display("FAIL en_resume: req=%b addr=%h want 1/%h", imem_req, imem_addr, model_pc);
        else passed++;
        fetch(1'b0, 32'd0, 1'b1, 32'hFFFF_FFF0, 4);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            fetch($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 2) == 0, $urandom,
                  $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_add2();
        fetch(1'b1, 32'h0000_0100, 1'b0, 32'd0, 0);
        imem_ready = 1'b1;
        @(negedge clock);
        imem_ready = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        total++;
        if (pc !== 32'd0 || imem_req !== 1'b0 || adder_op1 !== 32'd0 || adder_op2 !== 32'd0)
            $display("FAIL reset_in_add2: pc=%h req=%b op1=%h op2=%h want 0/0/0/0",
                     pc, imem_req, adder_op1, adder_op2);
        else passed++;
        @(negedge clock);
        reset = 1'b1;
        model_pc = 32'd0;
        fetch(1'b0, 32'd0, 1'b0, 32'd0, 0);
    endtask

    task automatic test_halt();
        halt = 1'b1;
        @(negedge clock);
        halt = 1'b0;
        total++;
        if (imem_req !== 1'b0 || halted !== 1'b1)
            $display("FAIL halt_enter: req=%b halted=%b want 0/1", imem_req, halted);
        else passed++;
        imem_ready = 1'b1; jump_valid = 1'b1; jump_target = 32'h800;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            total++;
            if (imem_req !== 1'b0 || halted !== 1'b1 || pc !== model_pc || redirect_ack !== 1'b0)
                $display("FAIL halt_hold: req=%b halted=%b pc=%h ack=%b want 0/1/%h/0",
                         imem_req, halted, pc, redirect_ack, model_pc);
            else passed++;
        end
        imem_ready = 1'b0; jump_valid = 1'b0;
        do_reset();
        total++;
        if (halted !== 1'b0 || pc !== 32'd0)
            $display("FAIL halt_exit: halted=%b pc=%h want 0/00000000", halted, pc);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump_branch();
        test_wrap();
        test_freeze();
        test_random();
        test_reset_add2();
        test_halt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
